bf16_add_arb: RTL and testbench

Round-robin arbiter that shares one combinational `bf16_add` instance among `NREQ` independent requesters. Each cycle at most one requester's operand pair is granted, registered, passed through the adder and registered again. The sum returns on a single tagged result channel with valid/ready backpressure. It sits between the per-lane issue logic and the single adder datapath, providing a throughput of one addition per cycle.

---
 rtl/bf16_pkg.sv | 15 +
 rtl/bf16_add.sv | 132 +++++++++++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/bf16_add_arb.sv | 117 +++++++++++
 tb/tb_bf16_add_arb.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared bf16 types and constants for the adder datapath and its arbiter front end.
package bf16_pkg;

    // Field view of a bf16 word: sign, biased exponent, 7-bit fraction.
    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
    } bf16_t;

    localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE      = 16'h3F80;
    localparam logic [15:0] BF16_QNAN     = 16'h7FC0;

endpackage

// File: rtl/bf16_add.sv
// Combinational bf16 adder: subnormal inputs/outputs flush to signed zero,
// round-to-nearest-even, canonical quiet NaN on invalid operations.
module bf16_add
    import bf16_pkg::*;
(
    input  logic       sa_i,
    input  logic [7:0] ea_i,
    input  logic [6:0] ma_i,
    input  logic       sb_i,
    input  logic [7:0] eb_i,
    input  logic [6:0] mb_i,
    output logic       s_o,
    output logic [7:0] e_o,
    output logic [6:0] m_o
);

    bf16_t       a;
    bf16_t       b;
    bf16_t       big;
    bf16_t       sml;
    bf16_t       res;
    logic [7:0]  d;
    logic [23:0] sml_full;
    logic [23:0] sml_sh;
    logic [23:0] lost_mask;
    logic        sticky;
    logic [24:0] big_sig;
    logic [24:0] sml_sig;
    logic [24:0] sum;
    logic [23:0] norm;
    logic [4:0]  pos;
    logic [4:0]  lz;
    logic [9:0]  exp_w;
    logic        uflow;
    logic        round_up;
    logic [7:0]  mant_r;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;

    assign a = {sa_i, ea_i, ma_i};
    assign b = {sb_i, eb_i, mb_i};

    // Align the smaller magnitude, add/subtract, normalise, round, then patch specials.
    always_comb begin
        res       = bf16_t'(BF16_POS_ZERO);
        lost_mask = 24'd0;
        sticky    = 1'b0;
        sml_sh    = 24'd0;
        lz        = 5'd0;
        pos       = 5'd0;
        uflow     = 1'b0;

        a_nan = (a.e == 8'hFF) && (a.m != 7'd0);
        b_nan = (b.e == 8'hFF) && (b.m != 7'd0);
        a_inf = (a.e == 8'hFF) && (a.m == 7'd0);
        b_inf = (b.e == 8'hFF) && (b.m == 7'd0);

        // Larger magnitude first so the subtraction never goes negative.
        if ({a.e, a.m} >= {b.e, b.m}) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end

        d        = big.e - sml.e;
        big_sig  = {1'b0, (big.e != 8'd0), big.m, 16'd0};
        sml_full = (sml.e != 8'd0) ? {1'b1, sml.m, 16'd0} : 24'd0;

        if (d >= 8'd24) begin
            sticky = |sml_full;
        end else begin
            lost_mask = (24'd1 << d) - 24'd1;
            sml_sh    = sml_full >> d;
            sticky    = |(sml_full & lost_mask);
        end
        // Bits shifted out only matter as a sticky flag far below the round position.
        sml_sig = {1'b0, sml_sh[23:1], sml_sh[0] | sticky};

        sum = (big.s == sml.s) ? (big_sig + sml_sig) : (big_sig - sml_sig);

        for (int i = 0; i < 24; i++) begin
            if (sum[i]) begin
                pos = 5'(i);
            end
        end

        if (sum[24]) begin
            norm  = {sum[24:2], sum[1] | sum[0]};
            exp_w = {2'b00, big.e} + 10'd1;
        end else begin
            lz    = 5'd23 - pos;
            norm  = sum[23:0] << lz;
            exp_w = {2'b00, big.e} - {5'd0, lz};
            uflow = ({3'b000, lz} >= big.e);
        end

        round_up = norm[15] && ((|norm[14:0]) || norm[16]);
        mant_r   = {1'b0, norm[22:16]} + {7'd0, round_up};
        if (mant_r[7]) begin
            exp_w = exp_w + 10'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a.s != b.s))) begin
            res = bf16_t'(BF16_QNAN);
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if ((a.e == 8'd0) && (b.e == 8'd0)) begin
            // Only -0 + -0 keeps the minus sign.
            res = {a.s & b.s, 15'd0};
        end else if (!norm[23]) begin
            // Exact cancellation yields +0.
            res = bf16_t'(BF16_POS_ZERO);
        end else if (uflow) begin
            res = {big.s, 15'd0};
        end else if (exp_w >= 10'd255) begin
            res = {big.s, 8'hFF, 7'd0};
        end else begin
            res = {big.s, exp_w[7:0], mant_r[6:0]};
        end
    end

    assign s_o = res.s;
    assign e_o = res.e;
    assign m_o = res.m;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from the priority pointer and
// returns a one-hot grant, its index and the pointer value after that grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  prio,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic [IDW-1:0]  prio_next
);

    logic           found;
    logic [IDW-1:0] idx;

    // First requester at or after prio (modulo NREQ) wins, only while enabled.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(prio) + k) % NREQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
        prio_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : (gnt_id + IDW'(1));
    end

endmodule

// File: rtl/bf16_add_arb.sv
// Shares one bf16 adder among NREQ requesters: round-robin grant into an
// operand stage, adder between stages, tagged result stage with backpressure.
module bf16_add_arb
    import bf16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NREQ-1:0]    req_valid_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic [NREQ*16-1:0] req_a_i,
    input  logic [NREQ*16-1:0] req_b_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [15:0]        res_o,
    output logic [IDW-1:0]     res_id_o
);

    logic [15:0]     a_arr [NREQ];
    logic [15:0]     b_arr [NREQ];
    logic            s1_en;
    logic            s2_en;
    logic            v1;
    logic            v2;
    logic [IDW-1:0]  prio;
    logic [IDW-1:0]  prio_next;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            transfer;
    bf16_t           a1;
    bf16_t           b1;
    logic [IDW-1:0]  id1;
    bf16_t           sum;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a_i[16*gi +: 16];
            assign b_arr[gi] = req_b_i[16*gi +: 16];
        end
    endgenerate

    // A stage may load when it is empty or its contents move on this edge.
    assign s2_en = !v2 || res_ready_i;
    assign s1_en = !v1 || s2_en;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid_i),
        .en        (s1_en && nreset),
        .prio      (prio),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .prio_next (prio_next)
    );

    assign req_ready_o = nreset ? gnt : '0;
    assign transfer    = |gnt;

    bf16_add u_add (
        .sa_i (a1.s),
        .ea_i (a1.e),
        .ma_i (a1.m),
        .sb_i (b1.s),
        .eb_i (b1.e),
        .mb_i (b1.m),
        .s_o  (sum.s),
        .e_o  (sum.e),
        .m_o  (sum.m)
    );

    // Priority pointer advances past each granted requester.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prio <= '0;
        end else if (transfer) begin
            prio <= prio_next;
        end
    end

    // Operand stage: capture the granted pair, or empty out when nothing transfers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v1  <= 1'b0;
            a1  <= bf16_t'(BF16_POS_ZERO);
            b1  <= bf16_t'(BF16_POS_ZERO);
            id1 <= '0;
        end else if (s1_en) begin
            v1 <= transfer;
            if (transfer) begin
                a1  <= a_arr[gnt_id];
                b1  <= b_arr[gnt_id];
                id1 <= gnt_id;
            end
        end
    end

    // Result stage: holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v2       <= 1'b0;
            res_o    <= BF16_POS_ZERO;
            res_id_o <= '0;
        end else if (s2_en) begin
            v2       <= v1;
            res_o    <= sum;
            res_id_o <= id1;
        end
    end

    assign res_valid_o = v2;

endmodule

// File: tb/tb_bf16_add_arb.sv
// Directed bench for bf16_add_arb: per-requester operand queues feed the DUT,
// a scoreboard holds expected {id, sum} in grant order and checks each result.
module tb_bf16_add_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               nreset;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ*16-1:0] req_a_i;
    logic [NREQ*16-1:0] req_b_i;
    logic               res_valid_o;
    logic               res_ready_i;
    logic [15:0]        res_o;
    logic [IDW-1:0]     res_id_o;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
    } op_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] s;
    } exp_t;

    op_t             ops [NREQ][32];
    int              head [NREQ];
    int              tail [NREQ];
    exp_t            sb [$];
    int              grant_log [$];
    int              res_cyc [$];
    logic [NREQ-1:0] xfer_mask;
    int              cycle     = 0;
    int              checks    = 0;
    int              failures  = 0;
    int              res_count = 0;

    bf16_add_arb #(
        .NREQ (NREQ)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .res_id_o    (res_id_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop/compare delivered results, push expectations for new grants.
    always @(negedge clk) begin
        exp_t e;
        xfer_mask = req_valid_i & req_ready_o;
        if (!nreset) begin
            sb.delete();
        end else begin
            if (res_valid_o && res_ready_i) begin
                check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("res_id", {30'd0, res_id_o}, {30'd0, e.id});
                    check("res_sum", {16'd0, res_o}, {16'd0, e.s});
                    $display("result id=%0d sum=0x%04h cycle=%0d", res_id_o, res_o, cycle);
                end
                res_count++;
                res_cyc.push_back(cycle);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (xfer_mask[i]) begin
                    sb.push_back({2'(i), ops[i][head[i]].s});
                    grant_log.push_back(i);
                end
            end
        end
    end

    // Requester model: present queue heads, advance a queue after its transfer.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer_mask[i]) head[i]++;
            if (head[i] < tail[i]) begin
                req_valid_i[i]          = 1'b1;
                req_a_i[16*i +: 16]     = ops[i][head[i]].a;
                req_b_i[16*i +: 16]     = ops[i][head[i]].b;
            end else begin
                req_valid_i[i] = 1'b0;
            end
        end
    end

    task automatic push_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        ops[r][tail[r]] = {a, b, s};
        tail[r]++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic idle();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] != tail[i]) return 1'b0;
        end
        return (sb.size() == 0);
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step(1);
            n++;
            done = idle();
        end
        check({tag, "_drain"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int gbase;
        int rbase;
        int cbase;
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};

        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        xfer_mask   = '0;
        nreset      = 1'b0;
        res_ready_i = 1'b1;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;

        // Reset state, with a request already pending.
        step(2);
        push_op(0, 16'h3F80, 16'h3F80, 16'h4000);
        step(1);
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready_o}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_res", {16'd0, res_o}, 32'h0000);
        check("rst_res_id", {30'd0, res_id_o}, 32'd0);

        // Single request latency: grant now, result two cycles later.
        step(1);
        nreset = 1'b1;
        @(negedge clk);
        check("t1_grant", {28'd0, req_ready_o}, 32'b0001);
        @(negedge clk);
        check("t1_valid_early", {31'd0, res_valid_o}, 32'd0);
        @(negedge clk);
        check("t1_valid", {31'd0, res_valid_o}, 32'd1);
        check("t1_res", {16'd0, res_o}, 32'h4000);
        check("t1_id", {30'd0, res_id_o}, 32'd0);
        wait_drain("t1", 20);

        // Round robin from reset with all four requesters valid.
        nreset = 1'b0;
        step(2);
        push_op(0, 16'h3F80, 16'h3F80, 16'h4000);
        push_op(0, 16'h4000, 16'h3F80, 16'h4040);
        push_op(1, 16'h3F00, 16'h3F00, 16'h3F80);
        push_op(2, 16'h4040, 16'h3F80, 16'h4080);
        push_op(3, 16'h3F80, 16'hBF80, 16'h0000);
        gbase = grant_log.size();
        rbase = res_cyc.size();
        step(1);
        nreset = 1'b1;
        wait_drain("t2", 30);
        check("t2_grant_count", grant_log.size() - gbase, 32'd5);
        if (grant_log.size() >= gbase + 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("t2_grant%0d", k), grant_log[gbase + k], exp_rr[k]);
            end
        end
        if (res_cyc.size() >= rbase + 5) begin
            for (int k = 1; k < 5; k++) begin
                check($sformatf("t2_no_bubble%0d", k), res_cyc[rbase + k] - res_cyc[rbase + k - 1], 32'd1);
            end
        end

        // Backpressure: fill both stages, hold, then release.
        res_ready_i = 1'b0;
        cbase = res_count;
        push_op(1, 16'h3F80, 16'h3F80, 16'h4000);
        push_op(2, 16'h3F80, 16'h4000, 16'h4040);
        push_op(3, 16'h4040, 16'h4040, 16'h40C0);
        step(4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_stall_valid", {31'd0, res_valid_o}, 32'd1);
            check("t3_stall_res", {16'd0, res_o}, 32'h4000);
            check("t3_stall_id", {30'd0, res_id_o}, 32'd1);
            check("t3_full_ready", {28'd0, req_ready_o}, 32'd0);
        end
        step(1);
        res_ready_i = 1'b1;
        wait_drain("t3", 30);
        check("t3_result_count", res_count - cbase, 32'd3);

        // Pointer skip/wrap: set prio to 2, then req3 and req1 together.
        push_op(1, 16'h3F00, 16'h3F80, 16'h3FC0);
        wait_drain("t4_setup", 20);
        gbase = grant_log.size();
        push_op(3, 16'h4000, 16'h4000, 16'h4080);
        push_op(1, 16'h3F80, 16'h4040, 16'h4080);
        wait_drain("t4", 20);
        check("t4_grant_count", grant_log.size() - gbase, 32'd2);
        if (grant_log.size() >= gbase + 2) begin
            check("t4_first", grant_log[gbase], 32'd3);
            check("t4_second", grant_log[gbase + 1], 32'd1);
        end

        // Signed-zero passthrough on requester 2.
        cbase = res_count;
        push_op(2, 16'h0000, 16'h8000, 16'h0000);
        push_op(2, 16'h8000, 16'h3F80, 16'h3F80);
        wait_drain("t5", 20);
        check("t5_result_count", res_count - cbase, 32'd2);

        // Reset with both stages full; pointer must return to 0.
        res_ready_i = 1'b0;
        push_op(0, 16'h3F80, 16'h3F80, 16'h4000);
        push_op(1, 16'h4000, 16'h4000, 16'h4080);
        step(4);
        @(negedge clk);
        check("t6_pre_valid", {31'd0, res_valid_o}, 32'd1);
        check("t6_pre_ready", {28'd0, req_ready_o}, 32'd0);
        step(1);
        #1;
        nreset = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, res_valid_o}, 32'd0);
        check("t6_rst_ready", {28'd0, req_ready_o}, 32'd0);
        step(2);
        res_ready_i = 1'b1;
        for (int i = 0; i < NREQ; i++) tail[i] = head[i];
        cbase = res_count;
        gbase = grant_log.size();
        push_op(3, 16'h3F80, 16'h3F80, 16'h4000);
        push_op(1, 16'h3F00, 16'h3F80, 16'h3FC0);
        step(1);
        nreset = 1'b1;
        wait_drain("t6", 20);
        check("t6_result_count", res_count - cbase, 32'd2);
        check("t6_grant_count", grant_log.size() - gbase, 32'd2);
        if (grant_log.size() >= gbase + 2) begin
            check("t6_first_after_rst", grant_log[gbase], 32'd1);
            check("t6_second_after_rst", grant_log[gbase + 1], 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
